// File: rtl/pb_counter.sv
// Debounced push-button press counter: 2-flop synchronizer, four-state debounce FSM,
// one-cycle press pulse, debounced level output and a 4-bit up/down wrap-around counter.
module pb_counter #(
    parameter int unsigned DEB_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic       clr,
    input  logic       up,
    output logic       pressed,
    output logic       held,
    output logic [3:0] cnt
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYC - 1);

    state_t      state;
    logic [15:0] dcnt;
    logic        sync1;
    logic        sync_n;
    logic        accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync_n <= 1'b1;
        end else begin
            sync1  <= key_n;
            sync_n <= sync1;
        end
    end

    // The press is accepted in the same cycle the FSM leaves PRESS_WAIT for PRESSED.
    always_comb begin
        accept = (state == PRESS_WAIT) && !sync_n && (dcnt == DEB_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RELEASED;
            dcnt    <= '0;
            pressed <= 1'b0;
            held    <= 1'b0;
        end else begin
            pressed <= 1'b0;
            case (state)
                RELEASED: begin
                    if (!sync_n) begin
                        state <= PRESS_WAIT;
                        dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (sync_n) begin
                        state <= RELEASED;
                        dcnt  <= '0;
                    end else if (dcnt == DEB_LAST) begin
                        state   <= PRESSED;
                        dcnt    <= '0;
                        pressed <= 1'b1;
                        held    <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 16'd1;
                    end
                end
                PRESSED: begin
                    if (sync_n) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync_n) begin
                        state <= PRESSED;
                        dcnt  <= '0;
                    end else if (dcnt == DEB_LAST) begin
                        state <= RELEASED;
                        dcnt  <= '0;
                        held  <= 1'b0;
                    end else begin
                        dcnt <= dcnt + 16'd1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    dcnt  <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

    // Clear wins over a simultaneous accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= up ? cnt + 4'd1 : cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_pb_counter.sv
// Self-checking bench for pb_counter (DEB_CYC = 4): directed scenarios plus randomized
// button activity compared against a run-length reference model.
module tb_pb_counter;

    localparam int unsigned DEB = 4;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic       clr;
    logic       up;
    logic       pressed;
    logic       held;
    logic [3:0] cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: key samples delayed by the synchronizer, plus the length of the
    // current run of samples that disagree with the debounced level.
    logic       m_kd1, m_kd2;
    int         m_run;
    logic       m_held, m_pressed;
    logic [3:0] m_cnt;

    pb_counter #(.DEB_CYC(DEB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_n  (key_n),
        .clr    (clr),
        .up     (up),
        .pressed(pressed),
        .held   (held),
        .cnt    (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_kd1     = 1'b1;
        m_kd2     = 1'b1;
        m_run     = 0;
        m_held    = 1'b0;
        m_pressed = 1'b0;
        m_cnt     = 4'd0;
    endtask

    task automatic model_edge();
        logic s;
        logic acc;
        s     = m_kd2;
        m_kd2 = m_kd1;
        m_kd1 = key_n;
        acc   = 1'b0;
        // key_n is active-low, so a sample equal to the held level disagrees with it
        if (s == m_held) begin
            m_run++;
            if (m_run == int'(DEB) + 1) begin
                m_run  = 0;
                m_held = !m_held;
                acc    = m_held;
            end
        end else begin
            m_run = 0;
        end
        m_pressed = acc;
        if (clr)
            m_cnt = 4'd0;
        else if (acc)
            m_cnt = up ? m_cnt + 4'd1 : m_cnt - 4'd1;
    endtask

    task automatic cyc(input logic k, input logic c, input logic u);
        key_n = k;
        clr   = c;
        up    = u;
        @(posedge clk);
        model_edge();
        #1;
        check("pressed", 16'(pressed), 16'(m_pressed));
        check("held", 16'(held), 16'(m_held));
        check("cnt", 16'(cnt), 16'(m_cnt));
        if (pressed === 1'b1) pulses++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pressed", 16'(pressed), 16'd0);
        check("rst_held", 16'(held), 16'd0);
        check("rst_cnt", 16'(cnt), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic press(input logic u);
        repeat (8) cyc(1'b0, 1'b0, u);
        repeat (9) cyc(1'b1, 1'b0, u);
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 1'b1;
        clr   = 1'b0;
        up    = 1'b1;
        model_reset();
        #1;
        check("init_pressed", 16'(pressed), 16'd0);
        check("init_held", 16'(held), 16'd0);
        check("init_cnt", 16'(cnt), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean press: pulse and held exactly at edge 7.
        do_reset();
        pulses = 0;
        for (int e = 1; e <= 7; e++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (e == 6) check("clean_pre_pulse", 16'(pressed), 16'd0);
        end
        check("clean_pressed", 16'(pressed), 16'd1);
        check("clean_held", 16'(held), 16'd1);
        check("clean_cnt", 16'(cnt), 16'd1);
        cyc(1'b0, 1'b0, 1'b1);
        check("clean_pulse_width", 16'(pressed), 16'd0);
        repeat (10) cyc(1'b1, 1'b0, 1'b1);
        check("clean_release", 16'(held), 16'd0);
        check("clean_pulses", 16'(pulses), 16'd1);

        // Bounce: short low bursts are rejected.
        do_reset();
        pulses = 0;
        repeat (5) begin
            repeat (3) cyc(1'b0, 1'b0, 1'b1);
            repeat (3) cyc(1'b1, 1'b0, 1'b1);
        end
        check("bounce_pulses", 16'(pulses), 16'd0);
        check("bounce_cnt", 16'(cnt), 16'd0);

        // Wrap in both directions.
        do_reset();
        pulses = 0;
        repeat (16) press(1'b1);
        check("wrap_up_cnt", 16'(cnt), 16'd0);
        check("wrap_up_pulses", 16'(pulses), 16'd16);
        press(1'b0);
        check("wrap_down_cnt", 16'(cnt), 16'd15);

        // Release glitch while pressed.
        do_reset();
        pulses = 0;
        repeat (8) cyc(1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b1);
        for (int e = 0; e < 10; e++) begin
            cyc(1'b0, 1'b0, 1'b1);
            check("glitch_held", 16'(held), 16'd1);
        end
        check("glitch_pulses", 16'(pulses), 16'd1);
        check("glitch_cnt", 16'(cnt), 16'd1);
        repeat (10) cyc(1'b1, 1'b0, 1'b1);

        // Clear in the accepting cycle.
        do_reset();
        repeat (5) press(1'b1);
        check("clr_pre_cnt", 16'(cnt), 16'd5);
        pulses = 0;
        for (int e = 1; e <= 7; e++) cyc(1'b0, e == 7, 1'b1);
        check("clr_cnt", 16'(cnt), 16'd0);
        check("clr_pressed", 16'(pressed), 16'd1);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (9) cyc(1'b1, 1'b0, 1'b1);
        check("clr_pulses", 16'(pulses), 16'd1);

        // Reset in the middle of PRESS_WAIT with the key still held.
        do_reset();
        press(1'b1);
        pulses = 0;
        repeat (4) cyc(1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_pressed", 16'(pressed), 16'd0);
        check("midrst_held", 16'(held), 16'd0);
        check("midrst_cnt", 16'(cnt), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cyc(1'b0, 1'b0, 1'b1);
            if (e == 6) check("midrst_pre_pulse", 16'(pulses), 16'd0);
        end
        check("midrst_pressed_e7", 16'(pressed), 16'd1);
        check("midrst_cnt_e7", 16'(cnt), 16'd1);
        repeat (10) cyc(1'b1, 1'b0, 1'b1);
        check("midrst_pulses", 16'(pulses), 16'd1);

        // Randomized button runs with occasional clear, direction flips and resets.
        do_reset();
        for (int i = 0; i < 2500; ) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int j = 0; j < len; j++)
                cyc(lvl, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
            i += len;
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
